// File: rtl/food_placer.sv
// Food placement engine: draws LFSR candidates, drops off-grid ones, confirms free
// cells with the occupancy checker and publishes the first free one or a failure.
module food_placer #(
  parameter int GRID_W    = 15,
  parameter int GRID_H    = 20,
  parameter int MAX_TRIES = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] rng4,
  input  logic [4:0] rng5,
  output logic       rng_update,
  output logic       occ_req,
  output logic [3:0] occ_x,
  output logic [4:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [3:0] food_x,
  output logic [4:0] food_y,
  output logic       food_valid
);

  typedef enum logic [2:0] {
    IDLE, STEP, CAND, QUERY, REJECT, DONE_OK, DONE_FAIL
  } state_t;

  localparam int                TRY_W    = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0]  TRY_MAX  = TRY_W'(MAX_TRIES);
  localparam logic [3:0]        GRID_W_L = 4'(GRID_W);
  localparam logic [4:0]        GRID_H_L = 5'(GRID_H);

  state_t           state, state_n;
  logic [TRY_W-1:0] tries, tries_inc;
  logic [3:0]       cand_x;
  logic [4:0]       cand_y;
  logic             cand_ok;

  always_comb begin
    cand_x    = rng4 - 4'd1;
    cand_y    = rng5 - 5'd1;
    cand_ok   = (cand_x < GRID_W_L) && (cand_y < GRID_H_L);
    tries_inc = tries + TRY_W'(1);
    state_n   = state;
    case (state)
      IDLE:      if (start) state_n = STEP;
      STEP:      state_n = CAND;
      CAND:      state_n = cand_ok ? QUERY : REJECT;
      QUERY:     if (occ_ack) state_n = occ_hit ? REJECT : DONE_OK;
      REJECT:    state_n = (tries_inc == TRY_MAX) ? DONE_FAIL : STEP;
      DONE_OK:   state_n = IDLE;
      DONE_FAIL: state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tries      <= '0;
      rng_update <= 1'b0;
      occ_req    <= 1'b0;
      occ_x      <= '0;
      occ_y      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
    end else begin
      state      <= state_n;
      rng_update <= (state_n == STEP);
      occ_req    <= (state_n == QUERY);
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE_OK) || (state_n == DONE_FAIL);
      fail       <= (state_n == DONE_FAIL);
      if (state == IDLE && start) begin
        tries      <= '0;
        food_valid <= 1'b0;
      end
      if (state == CAND) begin
        occ_x <= cand_x;
        occ_y <= cand_y;
      end
      if (state == REJECT) tries <= tries_inc;
      if (state_n == DONE_OK) begin
        food_x     <= occ_x;
        food_y     <= occ_y;
        food_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: LFSR source model, occupancy responder, placement scoreboard.
module tb_food_placer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start;
  logic [3:0] rng4, occ_x, food_x;
  logic [4:0] rng5, occ_y, food_y;
  logic       rng_update, occ_req, busy, done, fail, food_valid;
  logic       occ_ack = 1'b0, occ_hit = 1'b0;

  logic       start_b;
  logic [3:0] rng4_b, occ_x_b, food_x_b;
  logic [4:0] rng5_b, occ_y_b, food_y_b;
  logic       rng_update_b, occ_req_b, busy_b, done_b, fail_b, food_valid_b;
  logic       occ_ack_b, occ_hit_b;

  food_placer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rng4(rng4), .rng5(rng5),
    .rng_update(rng_update), .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
    .occ_ack(occ_ack), .occ_hit(occ_hit), .busy(busy), .done(done), .fail(fail),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid));

  food_placer #(.MAX_TRIES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rng4(rng4_b), .rng5(rng5_b),
    .rng_update(rng_update_b), .occ_req(occ_req_b), .occ_x(occ_x_b), .occ_y(occ_y_b),
    .occ_ack(occ_ack_b), .occ_hit(occ_hit_b), .busy(busy_b), .done(done_b), .fail(fail_b),
    .food_x(food_x_b), .food_y(food_y_b), .food_valid(food_valid_b));

  // Random source models: x^4+x^3+1 and x^5+x^3+1, reseeded by reset.
  logic [3:0] l4, l4b;
  logic [4:0] l5, l5b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l4 <= 4'b1011; l5 <= 5'b00111; l4b <= 4'b1011; l5b <= 5'b00111;
    end else begin
      if (rng_update) begin
        l4 <= {l4[2:0], l4[3] ^ l4[0]};
        l5 <= {l5[3:0], l5[4] ^ l5[2]};
      end
      if (rng_update_b) begin
        l4b <= {l4b[2:0], l4b[3] ^ l4b[0]};
        l5b <= {l5b[3:0], l5b[4] ^ l5b[2]};
      end
    end
  end
  assign rng4 = l4;   assign rng5 = l5;
  assign rng4_b = l4b; assign rng5_b = l5b;

  // Second instance: checker answers every query at once, always occupied.
  assign occ_ack_b = occ_req_b;
  assign occ_hit_b = 1'b1;

  int upd_cnt = 0, upd_b = 0, q_b = 0;
  always @(posedge clk) begin
    if (rng_update) upd_cnt++;
    if (rng_update_b) upd_b++;
    if (occ_req_b && occ_ack_b) q_b++;
  end

  // Occupancy responder: acks after ack_delay waiting cycles; first hits_cfg queries are hits.
  int         ack_delay = 0, hits_cfg = 0, q_base = 0, wait_cnt = 0;
  logic [8:0] qlog[$];
  always @(negedge clk) begin
    if (!rst_n) begin
      occ_ack  = 1'b0;
      wait_cnt = 0;
    end else if (occ_ack) begin
      occ_ack = 1'b0;
    end else if (occ_req) begin
      if (wait_cnt < ack_delay) wait_cnt++;
      else begin
        occ_hit  = ((qlog.size() - q_base) < hits_cfg);
        occ_ack  = 1'b1;
        qlog.push_back({occ_x, occ_y});
        wait_cnt = 0;
      end
    end
  end

  typedef struct packed {
    logic       fail;
    logic [3:0] x;
    logic [4:0] y;
  } res_t;
  res_t exp_q[$];

  typedef struct {
    int              hits, n_upd, lat, nq;
    logic [2:0][8:0] q;
    logic [3:0]      fx;
    logic [4:0]      fy;
  } vec_t;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int h, int u, int l, int n, logic [8:0] a, logic [8:0] b,
                              logic [8:0] c, logic [3:0] x, logic [4:0] y);
    vec_t v;
    v.hits = h; v.n_upd = u; v.lat = l; v.nq = n;
    v.q = {c, b, a}; v.fx = x; v.fy = y;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", {rng_update, occ_req, occ_x, occ_y, busy, done, fail,
                          food_x, food_y, food_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run(input bit with_reset, input vec_t t);
    int   cyc, ub;
    bit   bad;
    res_t e;
    if (with_reset) do_reset();
    hits_cfg = t.hits;
    q_base   = qlog.size();
    ub       = upd_cnt;
    exp_q.push_back({1'b0, t.fx, t.fy});
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("accept_busy_upd_fv", {busy, rng_update, food_valid}, 3'b110);
    cyc = 1; bad = 1'b0;
    while (!done && cyc < 300) begin
      if (fail || (occ_req && (occ_x >= 4'd15 || occ_y >= 5'd20))) bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles", cyc);
      return;
    end
    chk("latency", cyc, t.lat);
    chk("no_fail_or_offgrid_query", bad, 0);
    chk("result_fail_x_y", {fail, food_x, food_y}, e);
    chk("food_valid_on_done", food_valid, 1);
    chk("occ_req_low_on_done", occ_req, 0);
    chk("rng_updates", upd_cnt - ub, t.n_upd);
    chk("query_count", qlog.size() - q_base, t.nq);
    for (int i = 0; i < t.nq && (q_base + i) < qlog.size(); i++)
      chk($sformatf("query%0d_xy", i), qlog[q_base + i], t.q[i]);
    @(negedge clk);
    chk("idle_after_done", {busy, done, fail, food_valid}, 4'b0001);
  endtask

  vec_t vecs[3];
  vec_t again;

  initial begin
    int   cyc, ub;
    res_t e;
    rst_n = 1'b0; start = 1'b0; start_b = 1'b0;
    vecs[0] = mk(0, 1, 4, 1, {4'd5, 5'd14}, 9'd0, 9'd0, 4'd5, 5'd14);
    vecs[1] = mk(1, 6, 20, 2, {4'd5, 5'd14}, {4'd7, 5'd16}, 9'd0, 4'd7, 5'd16);
    vecs[2] = mk(2, 7, 24, 3, {4'd5, 5'd14}, {4'd7, 5'd16}, {4'd0, 5'd2}, 4'd0, 5'd2);
    again   = mk(0, 5, 16, 1, {4'd7, 5'd16}, 9'd0, 9'd0, 4'd7, 5'd16);

    for (int v = 0; v < 3; v++) run(1'b1, vecs[v]);

    // Back-to-back placement without reset: LFSR continues, food_valid re-cleared.
    run(1'b1, vecs[0]);
    chk("food_valid_held_idle", food_valid, 1);
    run(1'b0, again);

    // MAX_TRIES=1 instance with every cell occupied.
    do_reset();
    ub = upd_b; q_base = q_b;
    exp_q.push_back({1'b1, 4'd0, 5'd0});
    start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    cyc = 1;
    while (!done_b && cyc < 100) begin @(negedge clk); cyc++; end
    e = exp_q.pop_front();
    chk("b_done_seen", done_b, 1);
    chk("b_latency", cyc, 5);
    chk("b_fail_x_y", {fail_b, food_x_b, food_y_b}, e);
    chk("b_food_valid", food_valid_b, 0);
    chk("b_query_count", q_b - q_base, 1);
    chk("b_rng_updates", upd_b - ub, 1);
    @(negedge clk);
    chk("b_fail_after_done", {fail_b, done_b, busy_b}, 3'b000);

    // Long ack wait with extra start pulses.
    do_reset();
    hits_cfg = 0; ack_delay = 10; q_base = qlog.size(); ub = upd_cnt;
    exp_q.push_back({1'b0, 4'd5, 5'd14});
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    while (!occ_req && cyc < 20) begin @(negedge clk); cyc++; end
    chk("hold_query_cycle", cyc, 3);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d_req_busy_xy", i), {occ_req, busy, occ_x, occ_y},
          {1'b1, 1'b1, 4'd5, 5'd14});
      start = (i % 2 == 0);
      @(negedge clk);
    end
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 50) begin @(negedge clk); cyc++; end
    e = exp_q.pop_front();
    chk("hold_done_seen", done, 1);
    chk("hold_result", {fail, food_x, food_y}, e);
    chk("hold_rng_updates", upd_cnt - ub, 1);
    chk("hold_query_count", qlog.size() - q_base, 1);
    ack_delay = 0;
    @(negedge clk);
    @(negedge clk);
    chk("hold_extra_start_ignored", {busy, rng_update}, 2'b00);

    // Reset abandoned while the query is outstanding.
    do_reset();
    ack_delay = 1000; q_base = qlog.size();
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    while (!occ_req && cyc < 20) begin @(negedge clk); cyc++; end
    chk("abort_query_seen", occ_req, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_async_drop", {occ_req, busy, food_valid, done, rng_update}, 5'd0);
    ack_delay = 0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("abort_no_ack", qlog.size() - q_base, 0);
    run(1'b0, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/food_placer.md
Name: food_placer

Overview:
- Consumer side of the snake game's pseudo-random source. On request, it pulls successive values from the 4-bit/5-bit LFSR generator and turns them into candidate food coordinates.
- Candidates outside the playfield are rejected immediately. In-range candidates are checked against the snake-body occupancy checker through a req/ack handshake.
- It publishes the first free cell, or reports failure after a bounded number of tries.
- Sits between the game controller (start/done) and the random generator (update/rng4/rng5).

Parameters:
- GRID_W, 15, playfield width in cells (1..15).
- GRID_H, 20, playfield height in cells (1..31).
- MAX_TRIES, 31, candidates evaluated before giving up (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a new food position; sampled only in IDLE
- rng4  in  4  random value from generator (nonzero, 1..15)
- rng5  in  5  random value from generator (nonzero, 1..31)
- rng_update  out  1  one-cycle pulse asking generator to advance
- occ_req  out  1  occupancy query valid
- occ_x  out  4  queried column
- occ_y  out  5  queried row
- occ_ack  in  1  occupancy answer valid (one cycle)
- occ_hit  in  1  1 = cell occupied; valid only with occ_ack
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of a placement attempt
- fail  out  1  valid with done; 1 = MAX_TRIES exhausted
- food_x  out  4  placed food column
- food_y  out  5  placed food row
- food_valid  out  1  food_x/food_y hold a placed position

Behaviour:
- Reset values: all outputs 0; state IDLE; try counter 0.
- Candidate mapping: cand_x = rng4-1 (0..14), cand_y = rng5-1 (0..30). In range iff cand_x < GRID_W and cand_y < GRID_H.
- All outputs are registered.
- States:
  - IDLE: start=1 → STEP; try counter cleared; food_valid cleared.
  - STEP: rng_update=1 for exactly this cycle → CAND.
  - CAND: rng4/rng5 now carry the advanced value; latch cand_x/cand_y into occ_x/occ_y. If in range → QUERY, else → REJECT.
  - QUERY: occ_req=1, occ_x/occ_y stable until occ_ack. occ_ack with occ_hit=0 → DONE_OK. occ_ack with occ_hit=1 → REJECT. Ack may arrive in the first QUERY cycle; wait is unbounded.
  - REJECT: try counter +1. If the incremented count == MAX_TRIES → DONE_FAIL, else → STEP.
  - DONE_OK: done=1, fail=0; food_x/food_y = candidate; food_valid=1 → IDLE.
  - DONE_FAIL: done=1, fail=1; food_valid stays 0 → IDLE.
- Out-of-range candidates never raise occ_req.
- occ_req deasserts in the cycle after occ_ack.
- occ_ack outside QUERY is ignored.
- Latency, best case: start sampled at edge 0 → rng_update high cycle 1 → occ_req high cycle 3 → with same-cycle ack, done high cycle 4.
- start while busy is ignored. start high in the same cycle done pulses is not seen; it is sampled next cycle in IDLE.
- fail stays 0 outside the done cycle.
- Try counter width: $clog2(MAX_TRIES+1). It never wraps.
- Async reset mid-operation: immediate return to IDLE, all outputs 0. Any in-flight occ_req drops; the occupancy checker must tolerate an abandoned request.

Test Plan:
Bench drives rng4/rng5 from an LFSR model seeded 4'b1011/5'b00111, advancing on rng_update, with default parameters.
1. Reset, then start, checker answers ack+hit=0 same cycle → single rng_update; occ_req at (5,14) in cycle 3; done cycle 4, fail=0, food=(5,14), food_valid=1.
2. Same as 1 but first answer hit=1, then free → second query at (7,16), after candidates (11,30),(8,29),(1,27),(3,23) are rejected with no occ_req; five further rng_update pulses; food=(7,16).
3. MAX_TRIES=1, checker always hit → exactly one query; done with fail=1; food_valid=0.
4. Hold occ_ack low 10 cycles in QUERY → occ_req, occ_x, occ_y stable throughout; busy=1; extra start pulses have no effect.
5. Assert rst_n low while occ_req=1 → occ_req, busy, food_valid drop asynchronously. After release, start reproduces scenario 1 from the reseeded LFSR.
6. After a successful placement, start again → food_valid clears on acceptance; new food is published on done.
